// File: rtl/uart_fifo_ctrl_pkg.sv
// Shared definitions for the UART FIFO controller: TX FSM encoding,
// MMIO address map and status-register bit positions.
package uart_fifo_ctrl_pkg;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_HOLD = 1'b1
    } tx_state_e;

    localparam logic [7:0] UART_DATA_ADDR = 8'h00;
    localparam logic [7:0] UART_STAT_ADDR = 8'h04;
    localparam logic [7:0] UART_CTRL_ADDR = 8'h08;

    localparam int STAT_TX_FULL  = 0;
    localparam int STAT_RX_VALID = 1;
    localparam int STAT_TX_OVF   = 2;
    localparam int STAT_RX_UNF   = 3;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count; push/pop self-gate on full/empty,
// clr empties it and overrides any push/pop on the same edge.
module uart_sync_fifo #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_W-1:0]     din,
    output logic [DATA_W-1:0]     dout,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic                  do_push, do_pop;

    assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; stale entries are never visible past the pointers.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// CPU-side UART buffer: TX/RX FIFOs, TX valid/ready FSM feeding the UART,
// occupancy outputs and sticky overflow/underflow flags.
module uart_fifo_ctrl
    import uart_fifo_ctrl_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3,
    parameter int DATA_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  cpu_wr_en,
    input  logic [DATA_W-1:0]     cpu_wr_data,
    input  logic                  cpu_rd_en,
    output logic [DATA_W-1:0]     cpu_rd_data,
    input  logic                  flush,
    input  logic                  clr_err,
    output logic [DEPTH_LOG2:0]   tx_count,
    output logic [DEPTH_LOG2:0]   rx_count,
    output logic                  tx_full,
    output logic                  rx_valid,
    output logic                  tx_ovf,
    output logic                  rx_unf,
    output logic [DATA_W-1:0]     DataIn,
    output logic                  DataInValid,
    input  logic                  DataInReady,
    input  logic [DATA_W-1:0]     DataOut,
    input  logic                  DataOutValid,
    output logic                  DataOutReady
);
    tx_state_e         state, state_nxt;
    logic              wr, rd, fl, clr;
    logic              tx_pop, tx_empty, rx_full, rx_empty, rx_push;
    logic [DATA_W-1:0] tx_dout, rx_dout;
    logic              ovf_evt, unf_evt;

    // All CPU-side commands are masked while the pipeline is stalled.
    assign wr  = cpu_wr_en && !stall;
    assign rd  = cpu_rd_en && !stall;
    assign fl  = flush && !stall;
    assign clr = clr_err && !stall && !flush;

    assign rx_push      = DataOutValid && DataOutReady;
    assign DataOutReady = !rx_full;
    assign rx_valid     = !rx_empty;
    assign cpu_rd_data  = rx_empty ? '0 : rx_dout;

    uart_sync_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (fl),
        .push  (wr),
        .pop   (tx_pop),
        .din   (cpu_wr_data),
        .dout  (tx_dout),
        .count (tx_count),
        .full  (tx_full),
        .empty (tx_empty)
    );

    uart_sync_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (fl),
        .push  (rx_push),
        .pop   (rd),
        .din   (DataOut),
        .dout  (rx_dout),
        .count (rx_count),
        .full  (rx_full),
        .empty (rx_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  state <= TX_IDLE;
        else if (fl) state <= TX_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            TX_IDLE: if (!tx_empty) state_nxt = TX_HOLD;
            TX_HOLD: if (DataInReady && tx_empty) state_nxt = TX_IDLE;
            default: state_nxt = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_pop      = 1'b0;
        DataInValid = 1'b0;
        case (state)
            TX_IDLE: tx_pop = !tx_empty;
            TX_HOLD: begin
                DataInValid = 1'b1;
                tx_pop      = DataInReady && !tx_empty;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      DataIn <= '0;
        else if (fl)     DataIn <= '0;
        else if (tx_pop) DataIn <= tx_dout;
    end

    // Errors use pre-edge occupancy; a new error beats a simultaneous clear.
    assign ovf_evt = wr && tx_full && !fl;
    assign unf_evt = rd && rx_empty && !fl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_ovf <= 1'b0;
            rx_unf <= 1'b0;
        end else begin
            if (ovf_evt)  tx_ovf <= 1'b1;
            else if (clr) tx_ovf <= 1'b0;
            if (unf_evt)  rx_unf <= 1'b1;
            else if (clr) rx_unf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Randomized scoreboard bench for uart_fifo_ctrl against a queue-based model.
module tb_uart_fifo_ctrl;
    localparam int DL    = 3;
    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall = 1'b0, cpu_wr_en = 1'b0, cpu_rd_en = 1'b0, flush = 1'b0, clr_err = 1'b0;
    logic [DW-1:0] cpu_wr_data = '0, cpu_rd_data, DataIn, DataOut = '0;
    logic [DL:0]   tx_count, rx_count;
    logic          tx_full, rx_valid, tx_ovf, rx_unf;
    logic          DataInValid, DataInReady = 1'b0, DataOutValid = 1'b0, DataOutReady;

    uart_fifo_ctrl #(.DEPTH_LOG2(DL), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .cpu_wr_en(cpu_wr_en), .cpu_wr_data(cpu_wr_data),
        .cpu_rd_en(cpu_rd_en), .cpu_rd_data(cpu_rd_data),
        .flush(flush), .clr_err(clr_err),
        .tx_count(tx_count), .rx_count(rx_count),
        .tx_full(tx_full), .rx_valid(rx_valid), .tx_ovf(tx_ovf), .rx_unf(rx_unf),
        .DataIn(DataIn), .DataInValid(DataInValid), .DataInReady(DataInReady),
        .DataOut(DataOut), .DataOutValid(DataOutValid), .DataOutReady(DataOutReady)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Scoreboards: bytes the UART must see in order, and expected CPU read data.
    logic [DW-1:0] sb_tx[$];
    logic [DW-1:0] sb_rd[$];
    // Reference model: TX bytes waiting in the FIFO, whether a byte is on offer
    // to the UART, RX contents, sticky flags.
    int            m_txcnt = 0;
    bit            m_hold = 0;
    logic [DW-1:0] m_rx[$];
    bit            m_ovf = 0, m_unf = 0;
    event          sample_ev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(sample_ev) begin
        if (DataInValid && DataInReady) begin
            if (sb_tx.size() == 0) check("tx_unexpected_byte", 32'(DataIn), 32'hFFFF_FFFF);
            else check("tx_data", 32'(DataIn), 32'(sb_tx.pop_front()));
        end
        if (cpu_rd_en && !stall) begin
            if (sb_rd.size() == 0) check("rd_unexpected", 32'(cpu_rd_data), 32'hFFFF_FFFF);
            else check("rd_data", 32'(cpu_rd_data), 32'(sb_rd.pop_front()));
        end
    end

    task automatic model_edge();
        bit ops, ovf_e, unf_e, pop;
        int pre;
        ops = !stall;
        if (ops && flush) begin
            sb_tx.delete();
            m_txcnt = 0;
            m_hold  = 0;
            m_rx.delete();
            return;
        end
        ovf_e = ops && cpu_wr_en && (m_txcnt == DEPTH);
        unf_e = ops && cpu_rd_en && (m_rx.size() == 0);
        if (ovf_e) m_ovf = 1; else if (ops && clr_err) m_ovf = 0;
        if (unf_e) m_unf = 1; else if (ops && clr_err) m_unf = 0;
        // UART side: a byte is offered whenever one is queued and the slot is free.
        pop = (!m_hold || DataInReady) && (m_txcnt > 0);
        if (m_hold && DataInReady && !pop) m_hold = 0;
        if (pop) begin m_hold = 1; m_txcnt--; end
        if (ops && cpu_wr_en && !ovf_e) begin
            m_txcnt++;
            sb_tx.push_back(cpu_wr_data);
        end
        pre = m_rx.size();
        if (ops && cpu_rd_en && pre > 0) void'(m_rx.pop_front());
        if (DataOutValid && pre < DEPTH) m_rx.push_back(DataOut);
    endtask

    task automatic step(input bit wr, input logic [DW-1:0] wd, input bit rd, input bit fl,
                        input bit ce, input bit st, input bit rdy, input bit dov,
                        input logic [DW-1:0] dob);
        @(negedge clk);
        cpu_wr_en = wr; cpu_wr_data = wd; cpu_rd_en = rd; flush = fl; clr_err = ce;
        stall = st; DataInReady = rdy; DataOutValid = dov; DataOut = dob;
        if (rd && !st) sb_rd.push_back(m_rx.size() > 0 ? m_rx[0] : '0);
        #2;
        check("tx_count", 32'(tx_count), 32'(m_txcnt));
        check("rx_count", 32'(rx_count), 32'(m_rx.size()));
        check("tx_full", 32'(tx_full), 32'(m_txcnt == DEPTH));
        check("rx_valid", 32'(rx_valid), 32'(m_rx.size() != 0));
        check("tx_ovf", 32'(tx_ovf), 32'(m_ovf));
        check("rx_unf", 32'(rx_unf), 32'(m_unf));
        check("DataInValid", 32'(DataInValid), 32'(m_hold));
        check("DataOutReady", 32'(DataOutReady), 32'(m_rx.size() < DEPTH));
        -> sample_ev;
        #1;
        model_edge();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, rdy, 0, 0);
    endtask

    initial begin
        int p_wr, p_rd, p_rdy, p_dov, p_fl, p_st, p_ce;
        #3;
        check("rst_tx_count", 32'(tx_count), 0);
        check("rst_rx_count", 32'(rx_count), 0);
        check("rst_DataInValid", 32'(DataInValid), 0);
        check("rst_DataIn", 32'(DataIn), 0);
        check("rst_DataOutReady", 32'(DataOutReady), 1);
        check("rst_cpu_rd_data", 32'(cpu_rd_data), 0);
        check("rst_flags", 32'({tx_ovf, rx_unf}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Short burst with UART ready, then overflow with UART stalled.
        step(1, 8'h41, 0, 0, 0, 0, 1, 0, 0);
        step(1, 8'h42, 0, 0, 0, 0, 1, 0, 0);
        step(1, 8'h43, 0, 0, 0, 0, 1, 0, 0);
        idle(5, 1);
        for (int i = 0; i < 10; i++) step(1, 8'h60 + 8'(i), 0, 0, 0, 0, 0, 0, 0);
        idle(3, 0);
        step(0, 0, 0, 1, 1, 0, 0, 0, 0);
        idle(2, 1);
        // RX fill past full, drain past empty, clear, stall with commands high.
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 8'h10 + 8'(i));
        for (int i = 0; i < 9; i++) step(0, 0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0);
        step(1, 8'h77, 1, 0, 0, 1, 0, 0, 0);
        idle(2, 1);

        for (int blk = 0; blk < 20; blk++) begin
            p_wr  = $urandom_range(10, 90);
            p_rd  = $urandom_range(10, 90);
            p_rdy = $urandom_range(10, 100);
            p_dov = $urandom_range(10, 90);
            p_fl  = (blk % 3 == 0) ? 2 : 0;
            p_st  = $urandom_range(0, 20);
            p_ce  = $urandom_range(0, 15);
            for (int c = 0; c < 150; c++)
                step($urandom_range(0, 99) < p_wr, 8'($urandom), $urandom_range(0, 99) < p_rd,
                     $urandom_range(0, 99) < p_fl, $urandom_range(0, 99) < p_ce,
                     $urandom_range(0, 99) < p_st, $urandom_range(0, 99) < p_rdy,
                     $urandom_range(0, 99) < p_dov, 8'($urandom));
        end
        idle(12, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
